// File: rtl/wb_write_arbiter.sv
// Register-file writeback arbiter: ALU results take priority over a small load/mul FIFO.
// Optional macro WB_BYPASS_EN adds a combinational lookup of pending writes for decode.
module wb_write_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_addr,
  input  logic [31:0]              alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_addr,
  input  logic [31:0]              mem_data,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  input  logic [4:0]               byp_addr1,
  input  logic [4:0]               byp_addr2,
  output logic                     byp_hit1,
  output logic                     byp_hit2,
  output logic [31:0]              byp_data1,
  output logic [31:0]              byp_data2,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [4:0]    fifo_addr_q [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;
  logic          alu_grant, push, pop;

  // Ready looks only at the registered count so it never depends on this cycle's pop.
  always_comb begin
    alu_grant = alu_valid & (alu_addr != 5'd0);
    mem_ready = (count_q < DEPTH_W);
    push      = mem_valid & mem_ready & (mem_addr != 5'd0);
    pop       = ~alu_grant & (count_q != '0);
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (alu_grant) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = alu_addr;
      rf_wdata_d = alu_data;
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = fifo_addr_q[rd_ptr_q];
      rf_wdata_d = fifo_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Storage needs no reset: an empty count makes stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= mem_addr;
      fifo_data_q[wr_ptr_q] <= mem_data;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign fifo_count = count_q;
  assign busy       = rf_we_q | (count_q != '0);

`ifdef WB_BYPASS_EN
  for (genvar gi = 0; gi < 2; gi++) begin : g_byp
    logic [4:0]    addr;
    logic          hit;
    logic [31:0]   data;
    logic [AW-1:0] idx;

    assign addr = (gi == 0) ? byp_addr1 : byp_addr2;

    // Walk oldest to youngest so the youngest FIFO match overrides the output stage.
    always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = rd_ptr_q;
      if (addr != 5'd0) begin
        if (rf_we_q && (rf_waddr_q == addr)) begin
          hit  = 1'b1;
          data = rf_wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
          idx = rd_ptr_q + AW'(i);
          if (((AW+1)'(i) < count_q) && (fifo_addr_q[idx] == addr)) begin
            hit  = 1'b1;
            data = fifo_data_q[idx];
          end
        end
      end
    end
  end

  assign byp_hit1  = g_byp[0].hit;
  assign byp_data1 = g_byp[0].data;
  assign byp_hit2  = g_byp[1].hit;
  assign byp_data2 = g_byp[1].data;
`else
  logic unused_byp;
  assign unused_byp = ^{byp_addr1, byp_addr2};
  assign byp_hit1   = 1'b0;
  assign byp_hit2   = 1'b0;
  assign byp_data1  = '0;
  assign byp_data2  = '0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios then random traffic,
// all compared against a queue-based model of the writeback rules.
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid, mem_ready;
  logic [4:0]  alu_addr, mem_addr, rf_waddr, byp_addr1, byp_addr2;
  logic [31:0] alu_data, mem_data, rf_wdata, byp_data1, byp_data2;
  logic        rf_we, byp_hit1, byp_hit2, busy;
  logic [$clog2(DEPTH):0] fifo_count;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .byp_addr1(byp_addr1), .byp_addr2(byp_addr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2),
    .fifo_count(fifo_count), .busy(busy)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  // Reference: pending mem results in arrival order plus the current output stage.
  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  int n_cmp = 0;
  int n_err = 0;
  bit last_acc;
  int peak;
  int cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void lookup(input logic [4:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
`ifdef WB_BYPASS_EN
    if (a != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!hit && q[i].a == a) begin
          hit = 1'b1;
          d   = q[i].d;
        end
      end
      if (!hit && m_we && m_addr == a) begin
        hit = 1'b1;
        d   = m_data;
      end
    end
`endif
  endfunction

  function automatic void model_reset();
    q.delete();
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endfunction

  // One clock: check combinational outputs mid-cycle, step the model at the edge,
  // then check registered outputs just after it. Inputs must be stable on entry.
  task automatic tick();
    logic        h;
    logic [31:0] d;
    ent_t        e;
    bit          acc;
    @(negedge clk);
    check("mem_ready", mem_ready, (q.size() < DEPTH));
    lookup(byp_addr1, h, d);
    check("byp_hit1", byp_hit1, h);
    check("byp_data1", byp_data1, d);
    lookup(byp_addr2, h, d);
    check("byp_hit2", byp_hit2, h);
    check("byp_data2", byp_data2, d);
    acc = rst_n && mem_valid && (q.size() < DEPTH);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      acc = 1'b0;
    end else begin
      if (alu_valid && alu_addr != 5'd0) begin
        m_we = 1'b1; m_addr = alu_addr; m_data = alu_data;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_we = 1'b1; m_addr = e.a; m_data = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (acc && mem_addr != 5'd0) q.push_back('{a: mem_addr, d: mem_data});
    end
    last_acc = acc;
    #1;
    check("rf_we", rf_we, m_we);
    check("rf_waddr", rf_waddr, m_addr);
    check("rf_wdata", rf_wdata, m_data);
    check("fifo_count", fifo_count, q.size());
    check("busy", busy, (m_we || q.size() != 0));
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
  endtask

  initial begin
    int k;
    rst_n = 1'b1;
    idle_inputs();
    byp_addr1 = 0; byp_addr2 = 0;
    model_reset();
    last_acc = 0;
    peak = 0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_fifo_count", fifo_count, 0);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rf_we", rf_we, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single ALU write
    alu_valid = 1; alu_addr = 5; alu_data = 32'h1234; byp_addr1 = 5;
    tick();
    idle_inputs();
    check("alu_wdata", rf_wdata, 32'h1234);
    check("alu_waddr", rf_waddr, 5);
    tick(); tick();

    // Back-to-back mem pushes, ALU idle
    peak = 0;
    for (int i = 1; i <= 4; i++) begin
      mem_valid = 1; mem_addr = 5'(i); mem_data = 32'h100 + i;
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    check("mem_stream_peak", peak, 1);

    // ALU held busy while five mem results are offered
    k = 0;
    for (int c = 0; c < 20; c++) begin
      alu_valid = (c < 8); alu_addr = 5'(7 + c); alu_data = 32'hA000 + c;
      mem_valid = (k < 5); mem_addr = 5'(16 + k); mem_data = 32'hB000 + k;
      tick();
      if (last_acc) k++;
    end
    idle_inputs();
    check("starve_accepts", k, 5);
    repeat (2) tick();

    // Two pending writes to the same register
    byp_addr1 = 3; byp_addr2 = 0;
    alu_valid = 1; alu_addr = 20; alu_data = 32'hC0;
    mem_valid = 1; mem_addr = 3; mem_data = 32'hA;
    tick();
    mem_data = 32'hB;
    tick();
    mem_valid = 0;
    tick(); tick();
    alu_valid = 0;
    repeat (4) tick();

    // Address 0 from both sources
    alu_valid = 1; alu_addr = 0; alu_data = 32'hDEAD;
    mem_valid = 1; mem_addr = 0; mem_data = 32'hBEEF;
    byp_addr2 = 0;
    repeat (3) tick();
    idle_inputs();
    check("zero_rf_we", rf_we, 0);
    tick();

    // Asynchronous reset with three entries pending
    alu_valid = 1; alu_addr = 9; alu_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1; mem_addr = 5'(24 + i); mem_data = 32'hE0 + i;
      tick();
    end
    mem_valid = 0;
    check("pre_rst_count", fifo_count, 3);
    rst_n = 1'b0;
    #1;
    check("arst_fifo_count", fifo_count, 0);
    check("arst_mem_ready", mem_ready, 1);
    check("arst_rf_we", rf_we, 0);
    check("arst_busy", busy, 0);
    model_reset();
    idle_inputs();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // Random traffic
    for (cyc = 0; cyc < 600; cyc++) begin
      alu_valid = ($urandom_range(0, 9) < 4);
      alu_addr  = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      if (!(mem_valid && !last_acc)) begin
        mem_valid = ($urandom_range(0, 9) < 6);
        mem_addr  = 5'($urandom_range(0, 7));
        mem_data  = $urandom;
      end
      byp_addr1 = 5'($urandom_range(0, 7));
      byp_addr2 = 5'($urandom_range(0, 7));
      tick();
    end
    idle_inputs();
    repeat (8) tick();
    check("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Writeback arbiter that drives the single write port of the CPU register file. It merges two result sources: the single-cycle ALU path, which cannot stall, and the multi-cycle load/mul path, which is flow-controlled and buffered in a small FIFO. Output is one registered write per cycle. Optional bypass lookup returns values that are committed-but-not-yet-written, so decode can read them before they reach the register file.

## Interface
- DEPTH, 4, load/mul FIFO entries; power of two, >= 2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result present this cycle; always accepted
- alu_addr  in  5  ALU destination register
- alu_data  in  32  ALU result
- mem_valid  in  1  load/mul result offered
- mem_ready  out  1  FIFO can accept (= count < DEPTH)
- mem_addr  in  5  load/mul destination register
- mem_data  in  32  load/mul result
- rf_we  out  1  registered write enable to register file
- rf_waddr  out  5  registered write address
- rf_wdata  out  32  registered write data
- byp_addr1, byp_addr2  in  5 each  decode read addresses for lookup
- byp_hit1, byp_hit2  out  1 each  pending write found for that address
- byp_data1, byp_data2  out  32 each  pending value
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy
- busy  out  1  rf_we | (fifo_count != 0)

## Operation
- Accept: mem handshake when mem_valid & mem_ready.
  - mem_addr == 0: accepted and discarded, not enqueued.
  - Otherwise pushed at the tail.
- ALU results with alu_addr == 0 are ignored.
- Grant each edge, in priority order:
  1. ALU, if alu_valid & alu_addr != 0.
  2. Otherwise FIFO head pop, if the FIFO is non-empty.
  3. Otherwise output stage loads rf_we = 0. rf_waddr and rf_wdata hold their previous values.
- No cut-through: a mem result always passes through the FIFO, even when the FIFO is empty.
- Push and pop in the same cycle: occupancy unchanged. Read and write pointers wrap modulo DEPTH.
- Full: mem_ready = 0. mem_valid is ignored; the source holds its data.
- Starvation: continuous ALU traffic starves the FIFO indefinitely. The pipeline guarantees gaps.
- Commit order equals grant order. For the same address, the later grant wins in the register file.
- Bypass, combinational, per port:
  - Search the youngest FIFO entry (nearest tail) with matching address first, then the output stage (rf_we & rf_waddr match).
  - byp_addr == 0 never hits.
  - On a miss: hit = 0, data = 0.
- Reset, asynchronous and valid mid-operation:
  - FIFO contents are discarded; pointers and count go to 0.
  - rf_we, rf_waddr and rf_wdata go to 0.
  - mem_ready = 1 and busy = 0 as soon as reset asserts.

## Timing
- ALU result sampled at edge k → rf_we = 1 during cycle k..k+1 → register file written at edge k+1.
- mem accepted at edge k → earliest pop at edge k+1 → register file written at edge k+2. Each cycle of ALU priority adds one cycle.
- mem_ready depends only on the registered count, never on the same-cycle pop.
- Bypass outputs settle combinationally in the same cycle from byp_addr and the registered state.
- Throughput is one register-file write per cycle.

## Configuration
- WB_BYPASS_EN defined:
  - Bypass search logic is present as described above.
- WB_BYPASS_EN undefined:
  - byp_hit1/2 are tied to 0 and byp_data1/2 are tied to 0.
  - Ports remain present; no search logic is synthesized.
  - All other behaviour is identical.

## Test plan
- Reset, then alu_valid = 1, alu_addr = 5, alu_data = 0x1234 for one cycle → next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0x1234. Register 5 reads 0x1234 afterward.
- mem pushes to addresses 1–4 on consecutive cycles with alu idle → writes appear in order 1, 2, 3, 4, each two cycles after its accept. fifo_count peaks at 1.
- alu_valid held high (addresses 7, 8, …) while 5 mem pushes are offered (DEPTH = 4):
  - mem_ready drops after the 4th accept.
  - No FIFO pop occurs while ALU is active.
  - After ALU stops, all 4 entries drain in order.
  - The 5th entry is accepted once ready returns.
- mem to address 3 = 0xA, then mem to address 3 = 0xB, with byp_addr1 = 3 and WB_BYPASS_EN defined:
  - byp_hit1 = 1 with data 0xB while both entries are pending.
  - After the final write, hit = 0.
  - With the macro undefined, hit = 0 throughout.
- Writes to address 0 from both sources, and byp_addr2 = 0 → no rf_we pulse, byp_hit2 = 0, mem_ready stays 1.
- rst_n asserted with 3 FIFO entries pending → fifo_count = 0, mem_ready = 1, rf_we = 0 immediately. No stale write occurs after release.
